serializer: RTL and testbench

Parallel-to-serial transmitter: accepts an NBITS-wide word over a val/rdy input interface and emits it one bit per transfer, LSB first, over a val/rdy serial output interface. It is the sending end of a bit-serial link whose receiving end captures each bit into latch/flip-flop storage. It is used wherever a word must cross a one-bit channel in the sequential-logic examples.

---
 rtl/serializer.sv | 82 ++++++++
 tb/tb_serializer.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/serializer.sv
// Parallel-to-serial transmitter: NBITS-wide word in, one bit per val/rdy transfer out, LSB first.
// Optional trailing even-parity bit when SERIALIZER_PARITY_EN is defined.
module serializer #(
   parameter int NBITS = 8
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             in_val,
   output logic             in_rdy,
   input  logic [NBITS-1:0] in_msg,
   output logic             out_val,
   input  logic             out_rdy,
   output logic             out_bit,
   output logic             out_last
);

`ifdef SERIALIZER_PARITY_EN
   localparam int FRAME_LEN = NBITS + 1;
`else
   localparam int FRAME_LEN = NBITS;
`endif
   localparam int CW = $clog2(NBITS + 2);
   localparam logic [CW-1:0] LAST_IDX = CW'(FRAME_LEN - 1);

   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] SEND = 1'b1;

   logic [0:0]       state;
   logic [NBITS-1:0] shreg;
   logic [CW-1:0]    count;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
         shreg <= '0;
         count <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (in_val) begin
                  shreg <= in_msg;
                  count <= '0;
                  state <= SEND;
               end
            end
            SEND: begin
               if (out_rdy) begin
                  shreg <= shreg >> 1;
                  count <= count + 1'b1;
                  // Returning to IDLE for one cycle guarantees no overlap between frames.
                  if (count == LAST_IDX)
                     state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign in_rdy   = (state == IDLE);
   assign out_val  = (state == SEND);
   assign out_last = out_val && (count == LAST_IDX);

`ifdef SERIALIZER_PARITY_EN
   localparam logic [CW-1:0] DATA_END = CW'(NBITS);

   logic par;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         par <= 1'b0;
      else if (state == IDLE && in_val)
         par <= ^in_msg;
   end

   // Once the data bits are exhausted the parity bit takes the line.
   assign out_bit = out_val && ((count < DATA_END) ? shreg[0] : par);
`else
   assign out_bit = out_val && shreg[0];
`endif

endmodule

// File: tb/tb_serializer.sv
// Scoreboard bench for serializer: the driver queues expected {bit,last} pairs on each
// accepted word, and a negedge monitor pops and compares on every serial transfer.
module tb_serializer;

`ifdef SERIALIZER_PARITY_EN
   localparam int FL = 9;
`else
   localparam int FL = 8;
`endif

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       in_val = 1'b0;
   logic       in_rdy;
   logic [7:0] in_msg = 8'h00;
   logic       out_val;
   logic       out_rdy = 1'b1;
   logic       out_bit;
   logic       out_last;

   serializer #(.NBITS(8)) dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .in_val   (in_val),
      .in_rdy   (in_rdy),
      .in_msg   (in_msg),
      .out_val  (out_val),
      .out_rdy  (out_rdy),
      .out_bit  (out_bit),
      .out_last (out_last)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int fails = 0;
   int cyc = 0;
   int xfers = 0;
   bit stall_mode = 1'b0;
   logic [1:0] sb[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // out_rdy pattern 1,0,0,1 repeating while stall_mode is set.
   initial begin : rdy_driver
      int pidx;
      logic [3:0] pat;
      pidx = 0;
      pat = 4'b1001;
      forever begin
         @(posedge clk);
         #1;
         if (stall_mode) begin
            out_rdy = pat[3 - pidx];
            pidx = (pidx + 1) % 4;
         end else begin
            out_rdy = 1'b1;
            pidx = 0;
         end
      end
   end

   initial begin : monitor
      logic [1:0] e;
      bit hold_pending;
      bit expect_idle;
      logic hold_bit, hold_last;
      hold_pending = 0;
      expect_idle = 0;
      hold_bit = 0;
      hold_last = 0;
      forever begin
         @(negedge clk);
         if (expect_idle) begin
            check("in_rdy_after_last", in_rdy, 1'b1);
            check("out_val_after_last", out_val, 1'b0);
            expect_idle = 0;
         end
         if (hold_pending && out_val) begin
            check("stall_hold_bit", out_bit, hold_bit);
            check("stall_hold_last", out_last, hold_last);
         end
         hold_pending = 0;
         if (out_val && !out_rdy) begin
            hold_pending = 1;
            hold_bit = out_bit;
            hold_last = out_last;
         end
         if (out_val && out_rdy) begin
            xfers++;
            if (sb.size() == 0) begin
               checks++;
               fails++;
               $display("FAIL unexpected_transfer: got bit %0b last %0b, expected no transfer", out_bit, out_last);
            end else begin
               e = sb.pop_front();
               check("out_bit", out_bit, e[1]);
               check("out_last", out_last, e[0]);
            end
            if (out_last) expect_idle = 1;
         end
      end
   end

   task automatic send(input logic [7:0] msg, input bit keep, output int acc);
      bit ok;
      ok = 0;
      acc = -1;
      in_val = 1'b1;
      in_msg = msg;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (in_rdy) begin
            ok = 1;
            break;
         end
      end
      if (!ok) begin
         checks++;
         fails++;
         $display("FAIL accept_timeout: word %0h not accepted, required acceptance within 200 cycles", msg);
      end else begin
         @(posedge clk);
         #1;
         acc = cyc;
         for (int i = 0; i < 8; i++)
            sb.push_back({msg[i], (i == FL - 1) ? 1'b1 : 1'b0});
`ifdef SERIALIZER_PARITY_EN
         sb.push_back({^msg, 1'b1});
`endif
      end
      if (!keep) in_val = 1'b0;
   endtask

   task automatic drain();
      bit ok;
      ok = 0;
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         if (sb.size() == 0 && in_rdy) begin
            ok = 1;
            break;
         end
      end
      checks++;
      if (!ok) begin
         fails++;
         $display("FAIL drain_timeout: %0d bits outstanding, required 0", sb.size());
      end
      @(posedge clk);
      #1;
   endtask

   initial begin : driver
      int acc, a0, a1, a2, a3, x0;

      // Reset state
      #3;
      check("rst_in_rdy", in_rdy, 1'b1);
      check("rst_out_val", out_val, 1'b0);
      check("rst_out_bit", out_bit, 1'b0);
      check("rst_out_last", out_last, 1'b0);
      #9 reset_n = 1'b1;
      @(posedge clk);
      #1;

      // Basic frame A5: expect 1,0,1,0,0,1,0,1
      send(8'hA5, 0, acc);
      drain();

      // Stall: out_rdy toggles, exactly FL transfers
      x0 = xfers;
      stall_mode = 1'b1;
      send(8'h01, 0, acc);
      drain();
      stall_mode = 1'b0;
      check("stall_xfer_count", xfers - x0, FL);
      @(posedge clk);
      #1;

      // in_val held high with FF during the SEND of 00; then 07
      send(8'h00, 1, acc);
      send(8'hFF, 1, acc);
      send(8'h07, 0, acc);
      drain();

      // Mid-frame asynchronous reset after 3 bits of 3C
      send(8'h3C, 0, acc);
      x0 = xfers;
      for (int i = 0; i < 50 && (xfers - x0) < 3; i++)
         @(negedge clk);
      @(posedge clk);
      #2;
      reset_n = 1'b0;
      #1;
      check("midrst_in_rdy", in_rdy, 1'b1);
      check("midrst_out_val", out_val, 1'b0);
      check("midrst_out_bit", out_bit, 1'b0);
      check("midrst_out_last", out_last, 1'b0);
      sb.delete();
      @(posedge clk);
      #3 reset_n = 1'b1;
      @(posedge clk);
      #1;
      send(8'hC3, 0, acc);
      drain();

      // Back-to-back: FL+1 cycles per word
      send(8'h00, 1, a0);
      send(8'hFF, 1, a1);
      send(8'h81, 1, a2);
      send(8'h7E, 0, a3);
      drain();
      check("b2b_gap_1", a1 - a0, FL + 1);
      check("b2b_gap_2", a2 - a1, FL + 1);
      check("b2b_gap_3", a3 - a2, FL + 1);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation time exceeded limit");
      $fatal(1, "watchdog");
   end

endmodule
